freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of a slow external or divided-clock signal against the 100 MHz board clock and shows the count on the 16 board LEDs.
- It is the receive end of the clock-divider chain: the divider produces slow clocks, and this block counts their rising edges over a fixed gate window.
- It latches each result and pulses a valid strobe so results can be checked in the bench.

Parameters:
- GATE_CYCLES, 100000000, length of the gate window in clk cycles (1 s at 100 MHz); must be >= 2.
- WIDTH, 16, width of the edge counter and the led output.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  synchronous active-low reset.
- sig_in  input  1  measured signal; asynchronous to clk.
- led  output  WIDTH  latched rising-edge count of the last completed gate window.
- valid  output  1  one-cycle pulse when led is updated.
- ovf  output  1  the last completed window saturated the counter.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears everything on that edge:
  - led=0, valid=0, ovf=0.
  - Sync FFs, previous-sample reg, edge counter, gate timer and settle counter all 0.
  - State = SETTLE.
  - Asserting reset mid-window discards the partial count with no valid pulse.
- Input path:
  - sig_in passes through a 2-FF synchronizer (s1, s2), then a previous-sample reg s3.
  - edge = s2 & ~s3.
  - Latency from a sig_in rise to edge high is 2-3 clk edges.
- Cycle numbering: cycle n is the n-th clk edge with rst_n sampled high.
- SETTLE state:
  - Lasts edges 1-3 (settle counter 0, 1, 2).
  - edge is ignored and the gate timer is held at 0.
  - This masks the spurious edge that a high sig_in would otherwise produce at reset release.
  - Transitions to GATE on edge 3.
- GATE state:
  - Gate timer counts 0..GATE_CYCLES-1 with width $clog2(GATE_CYCLES).
  - Each edge where edge=1 increments the counter, saturating at 2^WIDTH-1.
  - An increment attempted while the counter is saturated sets an internal sticky sat flag for that window.
- Terminal edge (timer == GATE_CYCLES-1):
  - led <= counter plus this cycle's edge, saturated.
  - ovf <= sat OR (saturation on this cycle).
  - valid <= 1.
  - counter <= 0, sat <= 0, timer <= 0.
  - State stays GATE, so there is no dead time between windows.
  - An edge on the terminal cycle belongs to the closing window.
- Window timing:
  - Windows are exactly GATE_CYCLES edges and contiguous: the first covers edges 4..3+GATE_CYCLES.
  - valid is high for the single cycle after edges 3+k*GATE_CYCLES, k >= 1; it is 0 at all other times.
- Output hold: led and ovf keep their values between terminal edges.
- Arithmetic: no wrap-around; the counter saturates and never overflows to 0.

Optional Feature:
- Macro: FREQ_METER_BOTH_EDGES_EN.
- Defined: edge = s2 ^ s3, so both rising and falling transitions are counted.
  - A 50%-duty signal of period P cycles reports 2*GATE_CYCLES/P.
  - Saturation and ovf rules are unchanged.
- Undefined: rising edges only, as above.

Test Plan:
All cases use GATE_CYCLES=100 and WIDTH=16 unless stated.
1. rst_n low for 3 cycles with sig_in toggling -> led=0, valid=0, ovf=0 during reset and through edge 102; first valid after edge 103.
2. sig_in toggles every 5 clk (period 10) -> valid pulses after edges 103, 203, 303, each exactly one cycle wide; led=10 from the second window on (the first may be 9 or 10 due to phase); ovf=0.
3. sig_in held high through reset and afterwards -> no spurious count; led=0 after edges 103 and 203.
4. WIDTH=4, sig_in period 2 clk -> led=15, ovf=1. Then sig_in period 20 -> the next full window gives led=5, ovf=0.
5. rst_n pulsed low for 1 cycle at edge 150 while sig_in has period 10 -> led=0 and ovf=0 immediately; no valid near edge 203; next valid 103 edges after reset release with led=10.
6. FREQ_METER_BOTH_EDGES_EN defined, sig_in period 10 -> steady-state led=20.

Source files
------------

// File: rtl/freq_meter.sv
// ============================================================================
// Module   : freq_meter
// Purpose  : Counts edges of a slow asynchronous signal over a fixed gate
//            window and latches the result onto the LEDs with a valid strobe.
//            Optional macro FREQ_METER_BOTH_EDGES_EN counts both edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] led,
    output logic             valid,
    output logic             ovf
);

    localparam int                    c_timer_w = $clog2(GATE_CYCLES);
    localparam logic [c_timer_w-1:0]  c_last    = c_timer_w'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0]      c_max     = '1;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_GATE   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic                   s3_q, s3_d;
    logic [1:0]             settle_q, settle_d;
    logic [c_timer_w-1:0]   timer_q, timer_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [WIDTH-1:0]       led_q, led_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic                   w_edge;
    logic                   w_sat_now;
    logic [WIDTH-1:0]       w_cnt_inc;

    always_comb begin
`ifdef FREQ_METER_BOTH_EDGES_EN
        w_edge    = s2_q ^ s3_q;
`else
        w_edge    = s2_q & ~s3_q;
`endif
        w_sat_now = w_edge && (cnt_q == c_max);
        w_cnt_inc = w_sat_now ? cnt_q : cnt_q + WIDTH'(w_edge);

        s1_d     = sig_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        state_d  = state_q;
        settle_d = settle_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        case (state_q)
            // Masks the false edge a high input produces when the sync chain leaves reset.
            ST_SETTLE: begin
                timer_d = '0;
                if (settle_q == 2'd2) begin
                    state_d = ST_GATE;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            ST_GATE: begin
                if (timer_q == c_last) begin
                    led_d   = w_cnt_inc;
                    ovf_d   = sat_q | w_sat_now;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    timer_d = '0;
                end else begin
                    cnt_d   = w_cnt_inc;
                    sat_d   = sat_q | w_sat_now;
                    timer_d = timer_q + c_timer_w'(1);
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SETTLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            settle_q <= 2'd0;
            timer_q  <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            led_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            settle_q <= settle_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign led   = led_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Scoreboard bench for freq_meter (GATE_CYCLES=100, WIDTH 16 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

`ifdef FREQ_METER_BOTH_EDGES_EN
    localparam int E = 2;
`else
    localparam int E = 1;
`endif

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        bit dc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sig16, sig4;
    logic [15:0] led16;
    logic [3:0]  led4;
    logic        valid16, valid4, ovf16, ovf4;

    int  half16, half4;
    bit  lvl16, lvl4;
    int  cyc;
    bit  rst_q;
    int  n_checks, n_fail;
    bit  zero16, zero4;
    exp_t q16[$];
    exp_t q4[$];

    freq_meter #(.GATE_CYCLES(100), .WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig16),
        .led(led16), .valid(valid16), .ovf(ovf16)
    );

    freq_meter #(.GATE_CYCLES(100), .WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig4),
        .led(led4), .valid(valid4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of edges since reset release, as seen at the next negedge
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
        rst_q <= !rst_n;
    end

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d (cyc %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    task automatic push16(input int lo, input int hi, input bit o);
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = o; e.dc = 1'b0;
        q16.push_back(e);
    endtask

    task automatic push4(input int lo, input int hi, input bit o, input bit dc);
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = o; e.dc = dc;
        q4.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int c16;
        c16 = 0;
        sig16 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (half16 == 0) sig16 = lvl16;
            else begin
                c16++;
                if (c16 >= half16) begin sig16 = ~sig16; c16 = 0; end
            end
        end
    end

    initial begin
        int c4;
        c4 = 0;
        sig4 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (half4 == 0) sig4 = lvl4;
            else begin
                c4++;
                if (c4 >= half4) begin sig4 = ~sig4; c4 = 0; end
            end
        end
    end

    initial begin
        forever begin
            bit   ev;
            exp_t e;
            @(negedge clk);
            ev = !rst_q && cyc >= 103 && ((cyc - 3) % 100 == 0);
            chk("valid16_timing", int'(valid16), int'(ev), int'(ev));
            chk("valid4_timing", int'(valid4), int'(ev), int'(ev));
            if (rst_q) begin
                chk("rst16_led", int'(led16), 0, 0);
                chk("rst16_ovf", int'(ovf16), 0, 0);
                chk("rst4_led", int'(led4), 0, 0);
                chk("rst4_ovf", int'(ovf4), 0, 0);
                zero16 = 1'b1;
                zero4  = 1'b1;
            end else begin
                if (zero16 && !valid16) chk("pre16_led", int'(led16) + int'(ovf16), 0, 0);
                if (zero4 && !valid4)   chk("pre4_led", int'(led4) + int'(ovf4), 0, 0);
                if (valid16) begin
                    zero16 = 1'b0;
                    if (q16.size() == 0) chk("q16_unexpected_valid", 1, 0, 0);
                    else begin
                        e = q16.pop_front();
                        chk("res16_led", int'(led16), e.lo, e.hi);
                        chk("res16_ovf", int'(ovf16), int'(e.ovf), int'(e.ovf));
                    end
                end
                if (valid4) begin
                    zero4 = 1'b0;
                    if (q4.size() == 0) chk("q4_unexpected_valid", 1, 0, 0);
                    else begin
                        e = q4.pop_front();
                        if (!e.dc) begin
                            chk("res4_led", int'(led4), e.lo, e.hi);
                            chk("res4_ovf", int'(ovf4), int'(e.ovf), int'(e.ovf));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both inputs toggling, then free-run four windows.
        rst_n  = 1'b0;
        half16 = 5;  lvl16 = 1'b0;
        half4  = 1;  lvl4  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_cyc(93);  push16(9*E, 10*E, 1'b0);  push4(15, 15, 1'b1, 1'b0);
        wait_cyc(193); push16(10*E, 10*E, 1'b0); push4(15, 15, 1'b1, 1'b0);
        wait_cyc(250); half4 = 10;
        wait_cyc(293); push16(10*E, 10*E, 1'b0); push4(0, 0, 1'b0, 1'b1);
        wait_cyc(393); push16(10*E, 10*E, 1'b0); push4(5*E, 5*E, 1'b0, 1'b0);

        // Single-cycle reset in the middle of window 5 discards it.
        wait_cyc(449);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(93);  push16(9*E, 10*E, 1'b0);  push4(4*E, 5*E, 1'b0, 1'b0);
        wait_cyc(193); push16(10*E, 10*E, 1'b0); push4(5*E, 5*E, 1'b0, 1'b0);

        // Inputs held high through reset and afterwards.
        wait_cyc(205);
        half16 = 0; lvl16 = 1'b1;
        half4  = 0; lvl4  = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(93);  push16(0, 0, 1'b0); push4(0, 0, 1'b0, 1'b0);
        wait_cyc(193); push16(0, 0, 1'b0); push4(0, 0, 1'b0, 1'b0);
        wait_cyc(210);

        chk("q16_drained", q16.size(), 0, 0);
        chk("q4_drained", q4.size(), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
